// File: rtl/riscmakers_pkg.sv
// riscmakers_pkg: shared data-cache / memory constants and types.
//   - line/word geometry (XLEN, PLEN, DCACHE_LINE_WIDTH, derived counts)
//   - MEMORY_REQUEST_SIZE_* encodings for the memory write port
//   - writeback_t: one dirty line handed from the dcache to the drain
//   - drain_state_t / DRAIN_CNT_WIDTH: state and word counter of the drain
package riscmakers_pkg;

    localparam int XLEN              = 32;
    localparam int PLEN              = 32;
    localparam int DCACHE_LINE_WIDTH = 128;

    localparam int NUMBER_OF_WORDS_IN_DCACHE_BLOCK = DCACHE_LINE_WIDTH / XLEN;
    localparam int DCACHE_LINE_BYTES               = DCACHE_LINE_WIDTH / 8;
    localparam int DCACHE_OFFSET_WIDTH             = $clog2(DCACHE_LINE_BYTES);
    localparam int WORD_BYTES_LOG2                 = $clog2(XLEN / 8);

    localparam logic [2:0] MEMORY_REQUEST_SIZE_ONE_BYTE   = 3'b000;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_TWO_BYTES  = 3'b001;
    localparam logic [2:0] MEMORY_REQUEST_SIZE_FOUR_BYTES = 3'b010;

    // Width of the word counter used while draining one line.
    localparam int DRAIN_CNT_WIDTH = $clog2(NUMBER_OF_WORDS_IN_DCACHE_BLOCK);

    typedef struct packed {
        logic                         flag;     // 1: line is dirty and must be written back
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic [PLEN-1:0]              address;
    } writeback_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } drain_state_t;

endpackage

// File: rtl/dcache_writeback_drain_if.sv
// dcache_writeback_drain_if: bundles the dcache-side writeback handshake and
// the memory-side word write handshake of the drain.
//   master : the drain itself (accepts lines, issues memory writes)
//   slave  : the environment (dcache offering lines, memory granting/acking)
interface dcache_writeback_drain_if;
    import riscmakers_pkg::*;

    logic              wb_valid;
    writeback_t        wb;
    logic              wb_ready;
    logic              mem_req;
    logic              mem_gnt;
    logic [PLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [2:0]        mem_size;
    logic              mem_ack;

    modport master (
        input  wb_valid, wb, mem_gnt, mem_ack,
        output wb_ready, mem_req, mem_addr, mem_wdata, mem_size
    );

    modport slave (
        output wb_valid, wb, mem_gnt, mem_ack,
        input  wb_ready, mem_req, mem_addr, mem_wdata, mem_size
    );

endinterface

// File: rtl/dcache_writeback_drain.sv
// dcache_writeback_drain: takes one dirty line from the dcache and writes it
// to main memory one XLEN word at a time, lowest word first.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_valid_i/wb_i/wb_ready_o   line offer from the dcache (transfer on valid&&ready)
//   mem_req_o/mem_gnt_i   word write request / grant
//   mem_addr_o/mem_wdata_o/mem_size_o   request payload (size is always 4 bytes)
//   mem_ack_i             write completion for the granted word
//   snoop_addr_i/snoop_hit_o   CPU address falls in the line being drained
//   busy_o                a line is held
//   done_o                pulses in the cycle the last word is acknowledged
module dcache_writeback_drain
    import riscmakers_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_valid_i,
    input  writeback_t       wb_i,
    output logic             wb_ready_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [PLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [2:0]       mem_size_o,
    input  logic             mem_ack_i,
    input  logic [PLEN-1:0]  snoop_addr_i,
    output logic             snoop_hit_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [DRAIN_CNT_WIDTH-1:0] LAST_WORD =
        DRAIN_CNT_WIDTH'(NUMBER_OF_WORDS_IN_DCACHE_BLOCK - 1);
    // Keeps tag+index bits, clears the byte offset within a line.
    localparam logic [PLEN-1:0] LINE_MASK = ~PLEN'(DCACHE_LINE_BYTES - 1);

    drain_state_t                 state_q, state_d;
    logic [DRAIN_CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [DCACHE_LINE_WIDTH-1:0] data_q,  data_d;
    logic [PLEN-1:0]              addr_q,  addr_d;   // line base address

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Clean lines (flag=0) are still consumed, just never written.
                if (wb_valid_i && wb_i.flag) begin
                    data_d  = wb_i.data;
                    addr_d  = wb_i.address & LINE_MASK;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mem_ack_i) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // All handshake outputs decode straight from the state flop, so the
    // request payload cannot change while waiting for a grant.
    assign wb_ready_o  = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign busy_o      = (state_q != IDLE);
    assign mem_size_o  = MEMORY_REQUEST_SIZE_FOUR_BYTES;
    assign mem_addr_o  = addr_q + (PLEN'(cnt_q) << WORD_BYTES_LOG2);
    assign mem_wdata_o = data_q[cnt_q*XLEN +: XLEN];

    // done_o fires in the ack cycle itself; the following cycle is already
    // IDLE and can take the next line.
    assign done_o = (state_q == WAIT_ACK) && mem_ack_i && (cnt_q == LAST_WORD);

    assign snoop_hit_o = busy_o && (((snoop_addr_i ^ addr_q) & LINE_MASK) == '0);

endmodule

// File: tb/tb_dcache_writeback_drain.sv
// tb_dcache_writeback_drain: directed bench for dcache_writeback_drain.
// A small memory responder grants after a per-word delay and acks the cycle
// after each grant; every request cycle is checked against the expected
// address/data/size of the word in flight.
module tb_dcache_writeback_drain;
    import riscmakers_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [PLEN-1:0] snoop_addr;
    logic            snoop_hit, busy, done;

    always #5 clk = ~clk;

    dcache_writeback_drain_if u_if ();

    dcache_writeback_drain u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb_valid_i  (u_if.wb_valid),
        .wb_i        (u_if.wb),
        .wb_ready_o  (u_if.wb_ready),
        .mem_req_o   (u_if.mem_req),
        .mem_gnt_i   (u_if.mem_gnt),
        .mem_addr_o  (u_if.mem_addr),
        .mem_wdata_o (u_if.mem_wdata),
        .mem_size_o  (u_if.mem_size),
        .mem_ack_i   (u_if.mem_ack),
        .snoop_addr_i(snoop_addr),
        .snoop_hit_o (snoop_hit),
        .busy_o      (busy),
        .done_o      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // responder / monitor state
    int           gdly [4];
    int           held [4];
    int           widx, wcnt, nack, ndone;
    bit           ack_pend;
    logic [31:0]  exp_base;
    logic [127:0] exp_line;
    logic [31:0]  log_addr [4];
    logic [31:0]  log_data [4];

    // One clock: drive responder after the edge, check/log at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        u_if.wb_valid = 1'b0;
        u_if.mem_gnt  = 1'b0;
        u_if.mem_ack  = 1'b0;
        if (ack_pend) begin
            u_if.mem_ack = 1'b1;
            ack_pend     = 1'b0;
        end else if (u_if.mem_req) begin
            if (wcnt >= gdly[widx & 3]) begin
                u_if.mem_gnt = 1'b1;
                ack_pend     = 1'b1;
                wcnt         = 0;
            end else begin
                wcnt++;
            end
        end
        @(negedge clk);
        if (u_if.mem_req) begin
            if (widx < 4) begin
                chk("req_addr", u_if.mem_addr, exp_base + 32'(widx * 4));
                chk("req_data", u_if.mem_wdata, exp_line[widx*32 +: 32]);
                chk("req_size", u_if.mem_size, 3'b010);
                if (u_if.mem_gnt) begin
                    log_addr[widx] = u_if.mem_addr;
                    log_data[widx] = u_if.mem_wdata;
                end else begin
                    held[widx]++;
                end
            end else begin
                chk("extra_req", widx, 3);
            end
            if (u_if.mem_gnt) widx++;
        end
        if (u_if.mem_ack) nack++;
        if (done) ndone++;
    endtask

    task automatic start_line(input logic [31:0] addr, input logic [127:0] line,
                              input int d0, input int d1, input int d2, input int d3);
        gdly[0] = d0; gdly[1] = d1; gdly[2] = d2; gdly[3] = d3;
        for (int i = 0; i < 4; i++) begin
            held[i] = 0; log_addr[i] = '0; log_data[i] = '0;
        end
        widx = 0; wcnt = 0; nack = 0; ndone = 0; ack_pend = 1'b0;
        exp_base = addr & 32'hFFFF_FFF0;
        exp_line = line;
        u_if.wb_valid      = 1'b1;
        u_if.wb.flag       = 1'b1;
        u_if.wb.data       = line;
        u_if.wb.address    = addr;
        chk("rdy_idle", u_if.wb_ready, 1'b1);
        cycle();
        chk("busy_drain", busy, 1'b1);
        chk("rdy_drain", u_if.wb_ready, 1'b0);
    endtask

    task automatic finish_line();
        int n = 0;
        while (ndone == 0 && n < 80) begin
            cycle();
            n++;
        end
        chk("done_seen", ndone, 1);
        chk("ack_count", nack, 4);
        chk("req_count", widx, 4);
        cycle();
        chk("rdy_after", u_if.wb_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("done_once", ndone, 1);
    endtask

    logic [31:0] word_tab [4];
    logic [31:0] addr_tab [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        snoop_addr     = '0;
        u_if.wb_valid  = 1'b0;
        u_if.wb        = '0;
        u_if.mem_gnt   = 1'b0;
        u_if.mem_ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin gdly[i] = 0; held[i] = 0; end
        widx = 0; wcnt = 0; nack = 0; ndone = 0; ack_pend = 1'b0;
        exp_base = '0; exp_line = '0;

        // reset state
        cycle();
        cycle();
        chk("rst_ready", u_if.wb_ready, 1'b1);
        chk("rst_req", u_if.mem_req, 1'b0);
        chk("rst_addr", u_if.mem_addr, 32'h0);
        chk("rst_wdata", u_if.mem_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit", snoop_hit, 1'b0);
        rst = 1'b0;
        cycle();

        // aligned line, immediate grant/ack
        word_tab = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        addr_tab = '{32'h80000040, 32'h80000044, 32'h80000048, 32'h8000004C};
        start_line(32'h8000_0040, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   0, 0, 0, 0);
        finish_line();
        for (int i = 0; i < 4; i++) begin
            chk("a_addr", log_addr[i], addr_tab[i]);
            chk("a_data", log_data[i], word_tab[i]);
        end

        // unaligned offer address, grant on word 1 held off 3 cycles
        start_line(32'h8000_004C, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA},
                   0, 3, 0, 0);
        finish_line();
        chk("b_first_addr", log_addr[0], 32'h80000040);
        chk("b_w1_addr", log_addr[1], 32'h80000044);
        chk("b_w1_data", log_data[1], 32'hBBBBBBBB);
        chk("b_held_w1", held[1], 3);
        chk("b_held_w0", held[0], 0);

        // clean line is consumed and dropped
        widx = 0; nack = 0; ndone = 0;
        u_if.wb_valid   = 1'b1;
        u_if.wb.flag    = 1'b0;
        u_if.wb.data    = {4{32'h5A5A5A5A}};
        u_if.wb.address = 32'h8000_0100;
        chk("c_rdy", u_if.wb_ready, 1'b1);
        cycle();
        chk("c_rdy_after", u_if.wb_ready, 1'b1);
        chk("c_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) cycle();
        chk("c_reqs", widx, 0);
        chk("c_done", ndone, 0);
        chk("c_rdy_end", u_if.wb_ready, 1'b1);

        // snoop during and after a drain
        start_line(32'h8000_0050, {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A},
                   1, 0, 2, 0);
        snoop_addr = 32'h8000_0058;
        #1;
        chk("d_hit_in", snoop_hit, 1'b1);
        snoop_addr = 32'h8000_0080;
        #1;
        chk("d_hit_out", snoop_hit, 1'b0);
        finish_line();
        snoop_addr = 32'h8000_0058;
        #1;
        chk("d_hit_after", snoop_hit, 1'b0);

        // reset after the second ack abandons the line
        start_line(32'h8000_0040, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   0, 0, 0, 0);
        begin
            int n = 0;
            while (nack < 2 && n < 40) begin
                cycle();
                n++;
            end
        end
        chk("e_two_acks", nack, 2);
        rst = 1'b1;
        cycle();
        chk("e_rdy", u_if.wb_ready, 1'b1);
        chk("e_busy", busy, 1'b0);
        chk("e_req", u_if.mem_req, 1'b0);
        chk("e_addr", u_if.mem_addr, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("e_reqs", widx, 2);
        chk("e_done", ndone, 0);
        chk("e_acks", nack, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_writeback_drain.md
DCACHE_WRITEBACK_DRAIN -- requirements
Module: dcache_writeback_drain

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port wb_valid_i, input, 1: dcache offers a writeback_t entry.
REQ-004 SHALL have port wb_i, input, writeback_t: flag, DCACHE_LINE_WIDTH line data, PLEN address.
REQ-005 SHALL have port wb_ready_o, output, 1: drain can accept an entry; transfer occurs when wb_valid_i && wb_ready_o.
REQ-006 SHALL have port mem_req_o, output, 1: word write request to main memory.
REQ-007 SHALL have port mem_gnt_i, input, 1: memory accepts the current request.
REQ-008 SHALL have port mem_addr_o, output, PLEN: word-aligned write address.
REQ-009 SHALL have port mem_wdata_o, output, XLEN: write data word.
REQ-010 SHALL have port mem_size_o, output, 3: always MEMORY_REQUEST_SIZE_FOUR_BYTES.
REQ-011 SHALL have port mem_ack_i, input, 1: write completion for the granted request.
REQ-012 SHALL have port snoop_addr_i, input, PLEN: CPU load/store physical address.
REQ-013 SHALL have port snoop_hit_o, output, 1: snoop_addr_i falls in the line being drained.
REQ-014 SHALL have port busy_o, output, 1: a line is held or being drained.
REQ-015 SHALL have port done_o, output, 1: one-cycle pulse when the last word is acknowledged.

Function
REQ-016 SHALL use states IDLE, REQ, WAIT_ACK.
REQ-017 IDLE: wb_ready_o=1. On a transfer with wb_i.flag=1, SHALL capture data and the address with bits [DCACHE_OFFSET_WIDTH-1:0] cleared, clear the word counter, and go to REQ.
REQ-018 A transfer with wb_i.flag=0 SHALL be consumed and dropped: stay IDLE, no memory traffic, no done_o.
REQ-019 REQ: mem_req_o=1 and address/data/size stable until mem_gnt_i; on grant go to WAIT_ACK next cycle.
REQ-020 WAIT_ACK: mem_req_o=0; on mem_ack_i, if counter==NUMBER_OF_WORDS_IN_DCACHE_BLOCK-1 pulse done_o and go to IDLE, else increment counter and go to REQ.
REQ-021 Word k SHALL be data[k*XLEN +: XLEN] at line base + k*(XLEN/8), issued k=0 first, ascending.
REQ-022 Only one request SHALL be outstanding; mem_ack_i outside WAIT_ACK SHALL be ignored.
REQ-023 wb_ready_o SHALL be 0 outside IDLE; the first acceptance after done_o is in the following cycle (IDLE).
REQ-024 busy_o SHALL be 1 in REQ and WAIT_ACK, 0 in IDLE.
REQ-025 snoop_hit_o SHALL be combinational: busy_o && snoop_addr_i[PLEN-1:DCACHE_OFFSET_WIDTH]==captured line address tag+index bits.
REQ-026 Word counter width SHALL be $clog2(NUMBER_OF_WORDS_IN_DCACHE_BLOCK); it cannot wrap because the last word exits to IDLE.
REQ-027 Grant and ack arrive in different cycles; earliest ack is the cycle after grant.

Reset
REQ-028 With rst_i=1 at a clock edge the block SHALL enter IDLE, clear counter, buffered data and address; outputs then: wb_ready_o=1, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, snoop_hit_o=0.
REQ-029 Reset mid-drain SHALL abandon the line; no further requests and no done_o.

Structure
REQ-030 Drain state enum and word-counter width constant SHALL be added to riscmakers_pkg; writeback_t, NUMBER_OF_WORDS_IN_DCACHE_BLOCK, MEMORY_REQUEST_SIZE_* come from it.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 Line 0x8000_0040, words 0x11111111..0x44444444, gnt/ack immediate -> four requests at 0x80000040/44/48/4C with those words, size 3'b010, done_o once.
REQ-033 wb_i.address 0x8000_004C (unaligned) -> first request address 0x8000_0040.
REQ-034 flag=0 offer -> wb_ready_o stays 1, mem_req_o never asserted, no done_o.
REQ-035 Grant delayed 3 cycles on word 1 -> mem_addr_o=0x80000044 and data held stable all 3 cycles; total 4 acks.
REQ-036 During drain snoop 0x8000_0058 -> hit=1; 0x8000_0080 -> hit=0; after done_o, 0x8000_0058 -> hit=0.
REQ-037 rst_i asserted after second ack -> next cycle IDLE, wb_ready_o=1, no more requests, no done_o.
